// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage:
// state encoding, default widths and the entry bundle.
package fetch_pkg;

  localparam int FQ_PC_W    = 8;
  localparam int FQ_INSTR_W = 16;

  localparam logic [1:0] ST_FETCH    = 2'd0;
  localparam logic [1:0] ST_THROTTLE = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  typedef struct packed {
    logic [FQ_PC_W-1:0]    pc;
    logic [FQ_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Prefetch FIFO: first-word visible head,
// flush beats push and pop, sync reset.
module fetch_fifo #(
  parameter  int W     = 24,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  // Next pointers and occupancy; flush empties.
  always_comb begin
    do_push = push_i && !flush_i;
    do_pop  = pop_i && (cnt_q != '0) && !flush_i;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, drives the ROM,
// buffers tagged instructions for decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int          PC_W     = FQ_PC_W,
  parameter  int          INSTR_W  = FQ_INSTR_W,
  parameter  int          DEPTH    = 4,
  parameter  int unsigned RESET_PC = 0,
  localparam int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    rom_addr,
  output logic               rom_req,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_pc,
  input  logic [PC_W-1:0]    br_offset,
  output logic [CNT_W-1:0]   fifo_count
);

  localparam int EW = PC_W + INSTR_W;
  localparam logic [CNT_W:0] DEPTH_L =
    (CNT_W+1)'(DEPTH);

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic             inflight_q;
  logic             discard_q;
  logic [1:0]       state_q, state_d;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   occ_q;
  logic [CNT_W:0]   occ_d;

  assign occ_q = {1'b0, cnt}
               + (CNT_W+1)'(inflight_q);

  assign rom_req  = !rst && !br_taken
                 && (occ_q < DEPTH_L);
  assign rom_addr = fetch_pc_q;

  assign instr_valid = (cnt != '0);
  assign pop  = instr_valid && instr_ready;
  assign push = inflight_q && !discard_q
             && (state_q != ST_REDIRECT);

  // Next PC, request tag and predicted occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    occ_d      = occ_q;
    if (br_taken) begin
      fetch_pc_d = br_pc + br_offset;
      occ_d      = '0;
    end else begin
      occ_d = {1'b0, cnt}
            + (CNT_W+1)'(push)
            - (CNT_W+1)'(pop)
            + (CNT_W+1)'(rom_req);
      if (rom_req) begin
        fetch_pc_d = fetch_pc_q + 1'b1;
        req_pc_d   = fetch_pc_q;
      end
    end
  end

  // FSM: redirect wins, else throttle when full.
  always_comb begin
    state_d = ST_FETCH;
    unique case (1'b1)
      br_taken:
        state_d = ST_REDIRECT;
      (!br_taken && occ_d >= DEPTH_L):
        state_d = ST_THROTTLE;
      default:
        state_d = ST_FETCH;
    endcase
  end

  // Fetch-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= PC_W'(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      state_q    <= ST_FETCH;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= rom_req;
      discard_q  <= br_taken;
      state_q    <= state_d;
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (br_taken),
    .push_i  (push),
    .din_i   ({req_pc_q, rom_data}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (cnt)
  );

  assign instr_pc   = head[EW-1:INSTR_W];
  assign instr      = head[INSTR_W-1:0];
  assign fifo_count = cnt;

endmodule
